// File: rtl/decoder_3to8_reg_if.sv
// Select-side bus of the registered decoder: binary code and enables in,
// one-cold decode and its valid flag out.
interface decoder_3to8_reg_if #(
  parameter int SEL_W = 3
);
  logic [SEL_W-1:0]      iData;
  logic [1:0]            iEna;
  logic [(2**SEL_W)-1:0] oData;
  logic                  oValid;

  modport master (
    output iData,
    output iEna,
    input  oData,
    input  oValid
  );

  modport slave (
    input  iData,
    input  iEna,
    output oData,
    output oValid
  );
endinterface

// File: rtl/decoder_3to8_reg.sv
// Registered 3-to-8 decoder with 74x138-style dual enable (G1 high, G2 low)
// and active-low one-cold output; one clock of latency.
module decoder_3to8_reg #(
  parameter int                    SEL_W   = 3,
  parameter logic [(2**SEL_W)-1:0] RST_VAL = '1
) (
  input logic                iClk,
  input logic                iRst_n,
  decoder_3to8_reg_if.slave  bus
);
  localparam int OUT_W = 2**SEL_W;

  logic [OUT_W-1:0] nxtData;
  logic             nxtValid;

  // Decode the select code; a case on the enable pair lets a known disabling
  // bit win over X/Z on the other enable bit or on the select code.
  always_comb begin
    nxtData  = RST_VAL;
    nxtValid = 1'b0;
    case (bus.iEna)
      2'b10: begin
        nxtValid = 1'b1;
        for (int unsigned k = 0; k < OUT_W; k++) begin
          nxtData[k] = (bus.iData != SEL_W'(k));
        end
      end
      default: begin
        nxtData  = RST_VAL;
        nxtValid = 1'b0;
      end
    endcase
  end

  // Output register; reset forces the all-deasserted state immediately.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      bus.oData  <= RST_VAL;
      bus.oValid <= 1'b0;
    end else begin
      bus.oData  <= nxtData;
      bus.oValid <= nxtValid;
    end
  end
endmodule

// File: tb/tb_decoder_3to8_reg.sv
module tb_decoder_3to8_reg;
  logic clk   = 1'b0;
  logic rstN  = 1'b1;
  int   errors = 0;
  int   checks = 0;

  decoder_3to8_reg_if #(.SEL_W(3)) bus ();

  decoder_3to8_reg #(
    .SEL_W   (3),
    .RST_VAL (8'hFF)
  ) dut (
    .iClk   (clk),
    .iRst_n (rstN),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] data;
    logic [1:0] ena;
    logic [7:0] expData;
    logic       expValid;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: enabled only for G1=1, G2=0; then bit 'data' is the single zero.
  function automatic logic [7:0] refData(input logic [2:0] d, input logic [1:0] e);
    if (e === 2'b10) return ~(8'd1 << d);
    return 8'hFF;
  endfunction

  task automatic applyAndCheck(input vec_t v);
    @(negedge clk);
    bus.iData = v.data;
    bus.iEna  = v.ena;
    @(posedge clk); #1;
    check({v.name, " data"}, bus.oData, v.expData);
    check({v.name, " valid"}, {7'd0, bus.oValid}, {7'd0, v.expValid});
    repeat (3) @(posedge clk);
    #1;
    check({v.name, " hold"}, bus.oData, v.expData);
  endtask

  initial begin
    logic [2:0] prevData;
    logic [1:0] prevEna;
    logic [7:0] expD;

    vecs[0]  = '{"sel0", 3'd0, 2'b10, 8'hFE, 1'b1};
    vecs[1]  = '{"sel1", 3'd1, 2'b10, 8'hFD, 1'b1};
    vecs[2]  = '{"sel2", 3'd2, 2'b10, 8'hFB, 1'b1};
    vecs[3]  = '{"sel3", 3'd3, 2'b10, 8'hF7, 1'b1};
    vecs[4]  = '{"sel4", 3'd4, 2'b10, 8'hEF, 1'b1};
    vecs[5]  = '{"sel5", 3'd5, 2'b10, 8'hDF, 1'b1};
    vecs[6]  = '{"sel6", 3'd6, 2'b10, 8'hBF, 1'b1};
    vecs[7]  = '{"sel7", 3'd7, 2'b10, 8'h7F, 1'b1};
    vecs[8]  = '{"disG2", 3'bxxx, 2'bx1, 8'hFF, 1'b0};
    vecs[9]  = '{"disG1", 3'bxxx, 2'b0x, 8'hFF, 1'b0};
    vecs[10] = '{"reen0", 3'd0, 2'b10, 8'hFE, 1'b1};

    // Reset asserted before any clock edge
    bus.iData = 3'd3;
    bus.iEna  = 2'b10;
    #1 rstN = 1'b0;
    #2;
    check("rst data", bus.oData, 8'hFF);
    check("rst valid", {7'd0, bus.oValid}, 8'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;
    check("post-rst data", bus.oData, 8'hF7);
    check("post-rst valid", {7'd0, bus.oValid}, 8'd1);

    // Table sweep plus disable/re-enable
    for (int i = 0; i < 11; i++) applyAndCheck(vecs[i]);

    // Mid-operation reset pulse between edges
    @(negedge clk);
    bus.iData = 3'd5;
    bus.iEna  = 2'b10;
    @(posedge clk); #1;
    check("mid pre", bus.oData, 8'hDF);
    #1 rstN = 1'b0;
    #1;
    check("mid rst data", bus.oData, 8'hFF);
    check("mid rst valid", {7'd0, bus.oValid}, 8'd0);
    #1 rstN = 1'b1;
    @(posedge clk); #1;
    check("mid after", bus.oData, 8'hDF);

    // Glitch between edges has no effect
    @(negedge clk);
    bus.iData = 3'd2;
    @(posedge clk); #1;
    check("glitch pre", bus.oData, 8'hFB);
    #1 bus.iData = 3'd6;
    #1 bus.iEna  = 2'b01;
    #1 bus.iData = 3'd2;
    bus.iEna  = 2'b10;
    @(posedge clk); #1;
    check("glitch post", bus.oData, 8'hFB);

    // Randomized latency and invariant check
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      prevData = 3'($urandom_range(0, 7));
      prevEna  = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      bus.iData = prevData;
      bus.iEna  = prevEna;
      @(posedge clk); #1;
      expD = refData(prevData, prevEna);
      check("rand data", bus.oData, expD);
      check("rand valid", {7'd0, bus.oValid}, {7'd0, prevEna == 2'b10});
      checks++;
      if (bus.oValid ? ($countones(~bus.oData) != 1) : (bus.oData !== 8'hFF)) begin
        errors++;
        $display("FAIL invariant: got data=%h valid=%b, expected one-cold with valid=1 or FF with valid=0",
                 bus.oData, bus.oValid);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
